// File: rtl/fetch_queue.sv
// Instruction fetch stage: one outstanding imem read, a DEPTH-entry prefetch queue of {inst, pc},
// and a registered {inst, pc, valid} output to Decode. Handles redirects, Decode stalls and HALT.
module fetch_queue #(
    parameter int INST_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              do_branch,
    input  logic [ADDR_W-1:0] branch_address,
    input  logic              do_jump,
    input  logic [ADDR_W-1:0] jump_address,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_rdata,
    output logic [INST_W-1:0] out_inst,
    output logic [ADDR_W-1:0] out_pc,
    output logic              out_valid,
    output logic              halted
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {S_RUN, S_WAIT, S_FLUSH, S_HALTED} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [INST_W-1:0] out_inst_q, out_inst_d;
    logic [ADDR_W-1:0] out_pc_q, out_pc_d;
    logic              out_valid_q, out_valid_d;
    logic              halted_q, halted_d;

    logic [INST_W-1:0] inst_mem_q [DEPTH];
    logic [ADDR_W-1:0] pc_mem_q   [DEPTH];

    logic              redir, push, pop, is_halt;
    logic [ADDR_W-1:0] target;

    assign redir   = do_branch | do_jump;
    assign target  = do_branch ? branch_address : jump_address;
    assign is_halt = (imem_rdata[INST_W-1 -: 4] == 4'hF);
    // Data returning during a redirect belongs to the wrong path and is never queued.
    assign push    = (state_q == S_WAIT) && imem_ack && !redir;
    assign pop     = !stall && (count_q != '0) && !redir;

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        req_d       = req_q;
        addr_d      = addr_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
        out_inst_d  = out_inst_q;
        out_pc_d    = out_pc_q;
        out_valid_d = out_valid_q;

        if (pop)  head_d = head_q + PTR_W'(1);
        if (push) tail_d = tail_q + PTR_W'(1);

        if (redir) begin
            out_inst_d  = '0;
            out_pc_d    = '0;
            out_valid_d = 1'b0;
            head_d      = '0;
            tail_d      = '0;
            count_d     = '0;
        end else if (!stall) begin
            out_valid_d = (count_q != '0);
            out_inst_d  = (count_q != '0) ? inst_mem_q[head_q] : '0;
            out_pc_d    = (count_q != '0) ? pc_mem_q[head_q]   : '0;
        end

        unique case (state_q)
            S_RUN: begin
                if (redir) begin
                    fetch_pc_d = target;
                end else if (count_q < FULL) begin
                    req_d   = 1'b1;
                    addr_d  = fetch_pc_q;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_ack) begin
                    req_d = 1'b0;
                    if (redir) begin
                        fetch_pc_d = target;
                        state_d    = S_RUN;
                    end else begin
                        fetch_pc_d = addr_q + ADDR_W'(1);
                        if (is_halt) begin
                            state_d = S_HALTED;
                        end else if (count_d < FULL) begin
                            // Back-to-back issue keeps the bus busy without a RUN bubble.
                            req_d   = 1'b1;
                            addr_d  = addr_q + ADDR_W'(1);
                            state_d = S_WAIT;
                        end else begin
                            state_d = S_RUN;
                        end
                    end
                end else if (redir) begin
                    fetch_pc_d = target;
                    state_d    = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (redir) fetch_pc_d = target;
                if (imem_ack) begin
                    req_d   = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_HALTED: begin
                if (redir) begin
                    fetch_pc_d = target;
                    state_d    = S_RUN;
                end
            end
            default: state_d = S_RUN;
        endcase

        halted_d = (state_d == S_HALTED) && (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_RUN;
            fetch_pc_q  <= '0;
            req_q       <= 1'b0;
            addr_q      <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            out_inst_q  <= '0;
            out_pc_q    <= '0;
            out_valid_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            out_inst_q  <= out_inst_d;
            out_pc_q    <= out_pc_d;
            out_valid_q <= out_valid_d;
            halted_q    <= halted_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            inst_mem_q[tail_q] <= imem_rdata;
            pc_mem_q[tail_q]   <= addr_q;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign out_inst  = out_inst_q;
    assign out_pc    = out_pc_q;
    assign out_valid = out_valid_q;
    assign halted    = halted_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: a variable-latency instruction memory plus a stream model that expects
// consecutive PCs from each fetch start/redirect target, with the word stored at each PC.
module tb_fetch_queue;
    logic        clk = 1'b0;
    logic        rst, stall, do_branch, do_jump, imem_ack;
    logic [15:0] branch_address, jump_address, imem_rdata;
    logic        imem_req, out_valid, halted;
    logic [15:0] imem_addr, out_inst, out_pc;

    fetch_queue #(.INST_W(16), .ADDR_W(16), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .do_branch(do_branch), .branch_address(branch_address),
        .do_jump(do_jump), .jump_address(jump_address),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .out_inst(out_inst), .out_pc(out_pc), .out_valid(out_valid), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct { logic [15:0] inst; logic [15:0] pc; } ent_t;

    int          checks = 0, errors = 0, cyc = 0;
    logic [15:0] mem [0:65535];
    ent_t        got[$];
    logic [15:0] req_log[$];
    bit          busy, hs_en;
    int          cnt, lat_min, lat_max, ack_cnt;
    logic [15:0] lat_addr;

    task automatic fill_mem();
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom_range(16'hEFFF, 0));
    endtask

    // Memory: accepts a request when idle, acks after a random latency, then goes idle again.
    task automatic mem_step();
        if (imem_ack) begin
            imem_ack = 1'b0;
            busy     = 1'b0;
        end
        if (busy) begin
            if (hs_en) begin
                checks++;
                if (imem_req !== 1'b1 || imem_addr !== lat_addr) begin
                    errors++;
                    $display("FAIL handshake: req=%0b addr=%h, need req=1 addr=%h", imem_req, imem_addr, lat_addr);
                end
            end
            cnt--;
            if (cnt == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = mem[lat_addr];
                ack_cnt++;
            end
        end else if (imem_req) begin
            busy     = 1'b1;
            cnt      = int'($urandom_range(lat_max, lat_min));
            lat_addr = imem_addr;
            req_log.push_back(imem_addr);
        end
    endtask

    task automatic tick();
        bit st, rd;
        st = stall;
        rd = do_branch | do_jump;
        @(posedge clk);
        #1;
        mem_step();
        cyc++;
        if (!st && !rd && out_valid) got.push_back('{inst: out_inst, pc: out_pc});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1; stall = 1'b0; do_branch = 1'b0; do_jump = 1'b0;
        branch_address = '0; jump_address = '0;
        imem_ack = 1'b0; imem_rdata = '0; busy = 1'b0; hs_en = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        got.delete();
        req_log.delete();
        ack_cnt = 0;
    endtask

    task automatic test_reset();
        lat_min = 1; lat_max = 1;
        fill_mem();
        do_reset();
        checks += 6;
        if (imem_req !== 1'b0)  begin errors++; $display("FAIL reset_req: got %0b need 0", imem_req); end
        if (imem_addr !== '0)   begin errors++; $display("FAIL reset_addr: got %h need 0", imem_addr); end
        if (out_inst !== '0)    begin errors++; $display("FAIL reset_inst: got %h need 0", out_inst); end
        if (out_pc !== '0)      begin errors++; $display("FAIL reset_pc: got %h need 0", out_pc); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b need 0", out_valid); end
        if (halted !== 1'b0)    begin errors++; $display("FAIL reset_halted: got %0b need 0", halted); end
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
            errors++; $display("FAIL first_issue: req=%0b addr=%h need req=1 addr=0000", imem_req, imem_addr);
        end
    endtask

    task automatic test_sequential();
        logic [15:0] words [3];
        int ack_at, out_at;
        words[0] = 16'h1123; words[1] = 16'h2456; words[2] = 16'h5789;
        fill_mem();
        for (int i = 0; i < 3; i++) mem[i] = words[i];
        lat_min = 1; lat_max = 1;
        do_reset();
        ack_at = -1; out_at = -1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (imem_ack && ack_at < 0) ack_at = cyc;
            if (out_valid && out_at < 0) out_at = cyc;
        end
        checks++;
        if (ack_at < 0 || out_at - ack_at != 2) begin
            errors++; $display("FAIL seq_latency: ack->valid %0d cycles, need 2", out_at - ack_at);
        end
        checks++;
        if (got.size() < 3) begin
            errors++; $display("FAIL seq_count: got %0d words, need >=3", got.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got[i].inst !== words[i] || got[i].pc !== 16'(i)) begin
                    errors++;
                    $display("FAIL seq_word%0d: got %h/pc%h need %h/pc%h", i, got[i].inst, got[i].pc, words[i], 16'(i));
                end
            end
        end
    endtask

    task automatic test_stall_full();
        int n, bad;
        logic [15:0] h_inst, h_pc;
        fill_mem();
        lat_min = 1; lat_max = 1;
        do_reset();
        n = 0;
        while (!out_valid && n < 30) begin tick(); n++; end
        checks++;
        if (!out_valid) begin errors++; $display("FAIL stall_first_out: out_valid=0 after %0d cycles, need 1", n); end
        stall = 1'b1;
        h_inst = out_inst; h_pc = out_pc;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_inst !== h_inst || out_pc !== h_pc || out_valid !== 1'b1) bad++;
        end
        checks += 3;
        if (bad != 0)         begin errors++; $display("FAIL stall_hold: %0d cycles changed, need 0", bad); end
        if (ack_cnt != 5)     begin errors++; $display("FAIL stall_fill: %0d acks, need 5 (1 out + 4 queued)", ack_cnt); end
        if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_full_req: req=%0b need 0", imem_req); end
        stall = 1'b0;
        run(40);
        bad = 0;
        for (int i = 0; i < got.size(); i++)
            if (got[i].pc !== 16'(i) || got[i].inst !== mem[i]) bad++;
        checks++;
        if (bad != 0 || got.size() < 8) begin
            errors++; $display("FAIL stall_release: %0d bad of %0d words, need 0 bad and >=8", bad, got.size());
        end
    endtask

    task automatic test_redirect();
        int n;
        fill_mem();
        lat_min = 3; lat_max = 3;
        do_reset();
        n = 0;
        while (!out_valid && n < 40) begin tick(); n++; end
        stall = 1'b1;
        n = 0;
        while (!(busy && !imem_ack) && n < 40) begin tick(); n++; end
        checks++;
        if (!(busy && !imem_ack) || !out_valid) begin
            errors++; $display("FAIL redir_setup: busy=%0b out_valid=%0b, need 1/1", busy, out_valid);
        end
        do_branch = 1'b1; branch_address = 16'h0040;
        tick();
        do_branch = 1'b0; stall = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_inst !== '0 || out_pc !== '0) begin
            errors++; $display("FAIL redir_clear: %0b %h %h, need 0 0000 0000", out_valid, out_inst, out_pc);
        end
        got.delete(); req_log.delete();
        run(40);
        checks += 2;
        if (req_log.size() == 0 || req_log[0] !== 16'h0040) begin
            errors++; $display("FAIL redir_addr: first req %h, need 0040", req_log.size() ? req_log[0] : 16'hxxxx);
        end
        if (got.size() == 0 || got[0].pc !== 16'h0040 || got[0].inst !== mem[16'h0040]) begin
            errors++; $display("FAIL redir_first: %h/pc%h need %h/pc0040",
                               got.size() ? got[0].inst : 16'hxxxx, got.size() ? got[0].pc : 16'hxxxx, mem[16'h0040]);
        end
        do_branch = 1'b1; branch_address = 16'h0080;
        do_jump = 1'b1;   jump_address = 16'h0020;
        tick();
        do_branch = 1'b0; do_jump = 1'b0;
        got.delete();
        run(40);
        checks++;
        if (got.size() == 0 || got[0].pc !== 16'h0080) begin
            errors++; $display("FAIL branch_priority: first pc %h, need 0080", got.size() ? got[0].pc : 16'hxxxx);
        end
    endtask

    task automatic test_halt();
        int present_at, halt_at, saw4;
        fill_mem();
        mem[3] = 16'hF000;
        lat_min = 1; lat_max = 2;
        do_reset();
        present_at = -1; halt_at = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid && out_inst == 16'hF000 && present_at < 0) present_at = cyc;
            if (halted && halt_at < 0) halt_at = cyc;
        end
        saw4 = 0;
        foreach (req_log[i]) if (req_log[i] == 16'h0004) saw4++;
        checks += 4;
        if (saw4 != 0) begin errors++; $display("FAIL halt_no_req: %0d requests for pc 4, need 0", saw4); end
        if (got.size() != 4 || got[3].inst !== 16'hF000 || got[3].pc !== 16'h0003) begin
            errors++; $display("FAIL halt_stream: %0d words delivered, need 4 ending F000/pc3", got.size());
        end
        if (present_at < 0 || halt_at < present_at || halt_at > present_at + 1) begin
            errors++; $display("FAIL halt_timing: halted at %0d, F000 shown at %0d", halt_at, present_at);
        end
        if (halted !== 1'b1 || imem_req !== 1'b0) begin
            errors++; $display("FAIL halt_state: halted=%0b req=%0b need 1/0", halted, imem_req);
        end
        do_jump = 1'b1; jump_address = 16'h0010;
        tick();
        do_jump = 1'b0;
        checks++;
        if (halted !== 1'b0) begin errors++; $display("FAIL halt_exit: halted=%0b need 0", halted); end
        got.delete(); req_log.delete();
        run(30);
        checks++;
        if (req_log.size() == 0 || req_log[0] !== 16'h0010 || got.size() == 0 || got[0].pc !== 16'h0010) begin
            errors++; $display("FAIL halt_resume: first req %h first pc %h, need 0010",
                               req_log.size() ? req_log[0] : 16'hxxxx, got.size() ? got[0].pc : 16'hxxxx);
        end
    endtask

    task automatic test_wrap();
        fill_mem();
        lat_min = 1; lat_max = 3;
        do_reset();
        run(5);
        do_jump = 1'b1; jump_address = 16'hFFFF;
        tick();
        do_jump = 1'b0;
        got.delete();
        run(30);
        checks++;
        if (got.size() < 2 || got[0].pc !== 16'hFFFF || got[0].inst !== mem[16'hFFFF] ||
            got[1].pc !== 16'h0000 || got[1].inst !== mem[0]) begin
            errors++; $display("FAIL wrap: first pcs %h,%h need FFFF,0000",
                               got.size() > 0 ? got[0].pc : 16'hxxxx, got.size() > 1 ? got[1].pc : 16'hxxxx);
        end
    endtask

    task automatic test_reset_midwait();
        int n;
        fill_mem();
        lat_min = 3; lat_max = 3;
        do_reset();
        n = 0;
        while (got.size() < 1 && n < 40) begin tick(); n++; end
        n = 0;
        while (!(busy && cnt == 1 && !imem_ack) && n < 40) begin tick(); n++; end
        checks++;
        if (!(busy && cnt == 1)) begin errors++; $display("FAIL midwait_setup: busy=%0b cnt=%0d need 1/1", busy, cnt); end
        hs_en = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== '0 || out_valid !== 1'b0 || out_inst !== '0 || halted !== 1'b0) begin
            errors++; $display("FAIL midwait_reset: req=%0b addr=%h valid=%0b inst=%h need all 0", imem_req, imem_addr, out_valid, out_inst);
        end
        got.delete(); req_log.delete();
        tick();
        hs_en = 1'b1;
        run(30);
        checks++;
        if (req_log.size() == 0 || req_log[0] !== 16'h0000 || got.size() < 2 ||
            got[0].pc !== 16'h0000 || got[0].inst !== mem[0] || got[1].pc !== 16'h0001) begin
            errors++; $display("FAIL midwait_restart: first %h/pc%h, need %h/pc0000",
                               got.size() ? got[0].inst : 16'hxxxx, got.size() ? got[0].pc : 16'hxxxx, mem[0]);
        end
    endtask

    task automatic test_random();
        logic [15:0] exp_pc, tgt, p_inst, p_pc;
        logic        p_v;
        bit          st, rd;
        ent_t        e;
        fill_mem();
        lat_min = 1; lat_max = 3;
        do_reset();
        exp_pc = '0;
        for (int i = 0; i < 500; i++) begin
            stall = ($urandom_range(99, 0) < 30);
            if ($urandom_range(99, 0) < 4) begin
                do_branch = 1'($urandom_range(1, 0));
                do_jump   = !do_branch || 1'($urandom_range(1, 0));
                branch_address = 16'($urandom);
                jump_address   = 16'($urandom);
            end
            st = stall; rd = do_branch | do_jump;
            tgt = do_branch ? branch_address : jump_address;
            p_inst = out_inst; p_pc = out_pc; p_v = out_valid;
            tick();
            do_branch = 1'b0; do_jump = 1'b0;
            if (rd) begin
                exp_pc = tgt;
                checks++;
                if (out_valid !== 1'b0) begin errors++; $display("FAIL rnd_redir_clear: valid=%0b need 0", out_valid); end
            end else if (st) begin
                checks++;
                if (out_inst !== p_inst || out_pc !== p_pc || out_valid !== p_v) begin
                    errors++; $display("FAIL rnd_stall_hold: %h/%h/%0b need %h/%h/%0b", out_inst, out_pc, out_valid, p_inst, p_pc, p_v);
                end
            end
            while (got.size() > 0) begin
                e = got.pop_front();
                checks++;
                if (e.pc !== exp_pc || e.inst !== mem[exp_pc]) begin
                    errors++; $display("FAIL rnd_stream: %h/pc%h need %h/pc%h", e.inst, e.pc, mem[exp_pc], exp_pc);
                end
                exp_pc = exp_pc + 16'd1;
            end
        end
        stall = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall_full();
        test_redirect();
        test_halt();
        test_wrap();
        test_reset_midwait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
